// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle MIPS controller.
//   - state_t     : FSM state encoding (4 bits, FETCH = 0)
//   - OP_*        : opcode field values
//   - FUNCT_*     : R-type funct field values
//   - ALU_*       : alucontrol codes driven to the ALU
//   - ALUOP_*     : internal aluop codes handed to the ALU decoder
//   - SRCB_*/PC_* : mux select codes
//   - op_supported: true for opcodes the FSM knows how to sequence
// Configuration macro: CTRL_BNE_EN adds the BNEEX state and accepts op 000101.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
`ifdef CTRL_BNE_EN
    JEX     = 4'd11,
    BNEEX   = 4'd12
`else
    JEX     = 4'd11
`endif
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  function automatic logic op_supported(input logic [5:0] opcode);
    logic ok;
    case (opcode)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
`ifdef CTRL_BNE_EN
      OP_BNE:                                        ok = 1'b1;
`endif
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_controller_aludec.sv
// mc_controller_aludec: combinational ALU decoder.
//   aluop      in  2  00 add, 01 sub, 10 decode funct
//   funct      in  6  R-type funct field
//   alucontrol out 3  ALU function select
// Unknown funct values and the unused aluop 11 fall back to add.
module mc_controller_aludec
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALU_ADD;
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle MIPS control unit (Moore FSM).
// Sequences one ALU, one unified memory and one register file.
// Ports:
//   clk, reset (sync, active-high)
//   op, funct         instruction fields from the instruction register
//   zero              ALU zero flag (branch resolution)
//   memready          memory finishes its access this cycle
//   iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
//   alusrcb, pcsrc, pcen, alucontrol   datapath controls
//   illegal           one-cycle pulse in DECODE on an unsupported opcode
// Configuration macro: CTRL_BNE_EN enables bne (op 000101) via BNEEX.
// Outputs are decoded combinationally from state (plus funct, zero,
// memready) so the datapath sees them in the same cycle as the state.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  state_t     state;
  state_t     next_state;
  logic [1:0] aluop;
  logic       pcwrite;
  logic       branch;
  logic       bne;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:   if (memready) next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = RTYPEEX;
          OP_BEQ:       next_state = BEQEX;
`ifdef CTRL_BNE_EN
          OP_BNE:       next_state = BNEEX;
`endif
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JEX;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:  next_state = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   if (memready) next_state = MEMWB;
      MEMWR:   if (memready) next_state = FETCH;
      RTYPEEX: next_state = RTYPEWB;
      ADDIEX:  next_state = ADDIWB;
      default: next_state = FETCH;
    endcase
  end

  always_comb begin
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SRCB_RT;
    pcsrc    = PC_ALU;
    aluop    = ALUOP_ADD;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    bne      = 1'b0;
    illegal  = 1'b0;
    case (state)
      FETCH: begin
        alusrcb = SRCB_FOUR;
        irwrite = memready;
        pcwrite = memready;
      end
      DECODE: begin
        alusrcb = SRCB_IMMSH;
        illegal = ~op_supported(op);
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      MEMRD:   iord = 1'b1;
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PC_ALUOUT;
        branch  = 1'b1;
      end
`ifdef CTRL_BNE_EN
      BNEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PC_ALUOUT;
        bne     = 1'b1;
      end
`endif
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      ADDIWB:  regwrite = 1'b1;
      JEX: begin
        pcsrc   = PC_JUMP;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    // The state register only returns to FETCH at the next edge, so while
    // reset is high the outputs are forced to the idle FETCH pattern now.
    if (reset) begin
      iord     = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      regwrite = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = SRCB_FOUR;
      pcsrc    = PC_ALU;
      aluop    = ALUOP_ADD;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      bne      = 1'b0;
      illegal  = 1'b0;
    end
  end

  assign pcen = pcwrite | (branch & zero) | (bne & ~zero);

  mc_controller_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed self-checking bench for mc_controller.
// A behavioural model tracks the step number inside the current
// instruction and the instruction class, using the per-class cycle counts
// and per-step control patterns; it is compared against the DUT every
// cycle. Directed literal checks pin key cycles of the model.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memready;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       pcen, illegal;
  logic [2:0] alucontrol;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .memready   (memready),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .pcen       (pcen),
    .alucontrol (alucontrol),
    .illegal    (illegal)
  );

  // ---------------- behavioural model ----------------
  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_BEQ = 3, C_ADDI = 4,
                 C_J = 5, C_ILL = 6, C_BNE = 7;

  int m_step = 0;
  int m_cls  = C_ILL;

  function automatic int classify(input logic [5:0] o);
    case (o)
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000000: return C_R;
      6'b000100: return C_BEQ;
      6'b001000: return C_ADDI;
      6'b000010: return C_J;
`ifdef CTRL_BNE_EN
      6'b000101: return C_BNE;
`endif
      default:   return C_ILL;
    endcase
  endfunction

  // Cycles per instruction with memory always ready (illegal: FETCH+DECODE).
  function automatic int latency(input int c);
    case (c)
      C_LW:  return 5;
      C_SW:  return 4;
      C_R:   return 4;
      C_ADDI:return 4;
      C_BEQ: return 3;
      C_BNE: return 3;
      C_J:   return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [2:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Packed as {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,
  //            alusrcb,pcsrc,pcen,alucontrol,illegal}
  function automatic logic [16:0] model_out(input int c, input int s,
      input logic mr, input logic z, input logic [5:0] fn, input logic rst);
    logic e_iord, e_mw, e_irw, e_rd, e_m2r, e_rw, e_a, e_pcw, e_br, e_bn, e_ill;
    logic [1:0] e_b, e_pcs;
    logic [2:0] e_alu;
    e_iord = 0; e_mw = 0; e_irw = 0; e_rd = 0; e_m2r = 0; e_rw = 0; e_a = 0;
    e_pcw = 0; e_br = 0; e_bn = 0; e_ill = 0;
    e_b = 2'b00; e_pcs = 2'b00; e_alu = 3'b010;
    if (rst) begin
      e_b = 2'b01;
    end else if (s == 0) begin
      e_b = 2'b01; e_irw = mr; e_pcw = mr;
    end else if (s == 1) begin
      e_b = 2'b11; e_ill = (c == C_ILL);
    end else begin
      case (c)
        C_LW, C_SW: begin
          if (s == 2) begin e_a = 1; e_b = 2'b10; end
          else if (s == 3) begin e_iord = 1; e_mw = (c == C_SW); end
          else begin e_m2r = 1; e_rw = 1; end
        end
        C_R: begin
          if (s == 2) begin e_a = 1; e_alu = rtype_alu(fn); end
          else begin e_rd = 1; e_rw = 1; end
        end
        C_ADDI: begin
          if (s == 2) begin e_a = 1; e_b = 2'b10; end
          else e_rw = 1;
        end
        C_BEQ, C_BNE: begin
          e_a = 1; e_pcs = 2'b01; e_alu = 3'b110;
          e_br = (c == C_BEQ); e_bn = (c == C_BNE);
        end
        C_J: begin e_pcs = 2'b10; e_pcw = 1; end
        default: ;
      endcase
    end
    return {e_iord, e_mw, e_irw, e_rd, e_m2r, e_rw, e_a, e_b, e_pcs,
            e_pcw | (e_br & z) | (e_bn & ~z), e_alu, e_ill};
  endfunction

  always @(posedge clk) begin : model_advance
    int c;
    logic waiting;
    if (reset) begin
      m_step = 0;
    end else begin
      c = (m_step == 1) ? classify(op) : m_cls;
      if (m_step == 1) m_cls = c;
      waiting = (m_step == 0) || (((c == C_LW) || (c == C_SW)) && m_step == 3);
      if (!(waiting && !memready)) begin
        m_step = m_step + 1;
        if (m_step >= latency(c)) m_step = 0;
      end
    end
  end

  wire [16:0] dut_vec = {iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                         alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal};
  int cyc_n = 0;

  always @(negedge clk) begin : compare
    logic [16:0] exp_vec;
    int c;
    c = (m_step == 1) ? classify(op) : m_cls;
    exp_vec = model_out(c, m_step, memready, zero, funct, reset);
    cyc_n++;
    checks++;
    if (dut_vec !== exp_vec) begin
      errors++;
      $display("FAIL model cycle=%0d step=%0d got=%b required=%b",
               cyc_n, m_step, dut_vec, exp_vec);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input logic [5:0] o, input logic [5:0] f, input logic z,
                     input logic mr, input logic r);
    @(posedge clk);
    #1;
    op = o; funct = f; zero = z; memready = mr; reset = r;
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got,
                     input logic [7:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000,
                         JMP = 6'b000010, BAD = 6'b111111;

  logic [5:0] fn_tab [5] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111000};
  logic [2:0] alu_tab [5] = '{3'b110, 3'b000, 3'b001, 3'b111, 3'b010};

  initial begin
    reset = 1'b1; op = RT; funct = 6'b100000; zero = 1'b0; memready = 1'b1;
    cyc(RT, 6'b100000, 0, 1, 1);
    chk("reset_irwrite", {7'd0, irwrite}, 8'd0);
    chk("reset_pcen", {7'd0, pcen}, 8'd0);
    chk("reset_alusrcb", {6'd0, alusrcb}, 8'd1);
    chk("reset_alucontrol", {5'd0, alucontrol}, 8'd2);

    // R-type add
    cyc(RT, 6'b100000, 0, 1, 0);
    chk("fetch_irwrite", {7'd0, irwrite}, 8'd1);
    cyc(RT, 6'b100000, 0, 1, 0);
    chk("decode_alusrcb", {6'd0, alusrcb}, 8'd3);
    cyc(RT, 6'b100000, 0, 1, 0);
    chk("rtype_add_alu", {5'd0, alucontrol}, 8'd2);
    cyc(RT, 6'b100000, 0, 1, 0);
    chk("rtypewb_rw_rd", {6'd0, regwrite, regdst}, 8'd3);

    // Other R-type functs
    for (int i = 0; i < 5; i++) begin
      cyc(RT, fn_tab[i], 0, 1, 0);
      cyc(RT, fn_tab[i], 0, 1, 0);
      cyc(RT, fn_tab[i], 0, 1, 0);
      chk("rtype_funct_alu", {5'd0, alucontrol}, {5'd0, alu_tab[i]});
      cyc(RT, fn_tab[i], 0, 1, 0);
    end

    // lw with two-cycle MEMRD stall: 7 cycles total
    cyc(LW, 0, 0, 1, 0);
    cyc(LW, 0, 0, 1, 0);
    cyc(LW, 0, 0, 1, 0);
    chk("memadr_alusrcb", {6'd0, alusrcb}, 8'd2);
    cyc(LW, 0, 0, 0, 0);
    chk("memrd1_iord", {7'd0, iord}, 8'd1);
    cyc(LW, 0, 0, 0, 0);
    chk("memrd2_iord", {7'd0, iord}, 8'd1);
    cyc(LW, 0, 0, 1, 0);
    chk("memrd3_iord", {7'd0, iord}, 8'd1);
    cyc(LW, 0, 0, 1, 0);
    chk("memwb_m2r_rw", {6'd0, memtoreg, regwrite}, 8'd3);
    cyc(BEQ, 0, 0, 0, 0);
    chk("lw_done_fetch_stall", {6'd0, irwrite, iord}, 8'd0);

    // beq taken (after one stalled FETCH)
    cyc(BEQ, 0, 0, 1, 0);
    chk("fetch_after_stall", {7'd0, irwrite}, 8'd1);
    cyc(BEQ, 0, 0, 1, 0);
    cyc(BEQ, 0, 1, 1, 0);
    chk("beq_taken", {2'd0, pcen, pcsrc, alucontrol}, 8'b00101110);
    cyc(BEQ, 0, 0, 1, 0);
    cyc(BEQ, 0, 0, 1, 0);
    cyc(BEQ, 0, 0, 1, 0);
    chk("beq_not_taken", {7'd0, pcen}, 8'd0);

    // sw, addi, j
    cyc(SW, 0, 0, 1, 0); cyc(SW, 0, 0, 1, 0); cyc(SW, 0, 0, 1, 0);
    cyc(SW, 0, 0, 1, 0);
    chk("memwr_strobe", {6'd0, memwrite, iord}, 8'd3);
    cyc(ADDI, 0, 0, 1, 0); cyc(ADDI, 0, 0, 1, 0); cyc(ADDI, 0, 0, 1, 0);
    cyc(ADDI, 0, 0, 1, 0);
    chk("addiwb", {6'd0, regwrite, regdst}, 8'd2);
    cyc(JMP, 0, 0, 1, 0); cyc(JMP, 0, 0, 1, 0); cyc(JMP, 0, 0, 1, 0);
    chk("jex", {5'd0, pcsrc, pcen}, 8'd5);

    // Illegal opcode
    cyc(BAD, 0, 0, 1, 0);
    cyc(BAD, 0, 0, 1, 0);
    chk("illegal_pulse", {4'd0, illegal, regwrite, memwrite, irwrite}, 8'd8);
    cyc(RT, 6'b100000, 0, 1, 0);
    chk("illegal_back_fetch", {6'd0, illegal, irwrite}, 8'd1);
    cyc(RT, 6'b100000, 0, 1, 0); cyc(RT, 6'b100000, 0, 1, 0);
    cyc(RT, 6'b100000, 0, 1, 0);

    // op 000101
`ifdef CTRL_BNE_EN
    cyc(BNE, 0, 0, 1, 0); cyc(BNE, 0, 0, 1, 0); cyc(BNE, 0, 0, 1, 0);
    chk("bne_taken", {7'd0, pcen}, 8'd1);
    cyc(BNE, 0, 1, 1, 0); cyc(BNE, 0, 1, 1, 0); cyc(BNE, 0, 1, 1, 0);
    chk("bne_not_taken", {7'd0, pcen}, 8'd0);
`else
    cyc(BNE, 0, 0, 1, 0);
    cyc(BNE, 0, 0, 1, 0);
    chk("bne_illegal", {7'd0, illegal}, 8'd1);
    cyc(RT, 6'b100000, 0, 1, 0);
    chk("bne_back_fetch", {7'd0, irwrite}, 8'd1);
    cyc(RT, 6'b100000, 0, 1, 0); cyc(RT, 6'b100000, 0, 1, 0);
    cyc(RT, 6'b100000, 0, 1, 0);
`endif

    // Reset in the middle of a stalled store
    cyc(SW, 0, 0, 1, 0); cyc(SW, 0, 0, 1, 0); cyc(SW, 0, 0, 1, 0);
    cyc(SW, 0, 0, 0, 0);
    chk("memwr_stalled", {7'd0, memwrite}, 8'd1);
    cyc(SW, 0, 0, 0, 1);
    chk("reset_mid_memwr", {6'd0, memwrite, iord}, 8'd0);
    cyc(SW, 0, 0, 0, 1);
    chk("reset_held_memwrite", {7'd0, memwrite}, 8'd0);
    cyc(SW, 0, 0, 0, 0);
    chk("post_reset_fetch_stall", {6'd0, irwrite, iord}, 8'd0);
    cyc(SW, 0, 0, 1, 0);
    chk("post_reset_fetch", {7'd0, irwrite}, 8'd1);
    cyc(SW, 0, 0, 1, 0); cyc(SW, 0, 0, 1, 0); cyc(SW, 0, 0, 1, 0);
    cyc(RT, 6'b100000, 0, 1, 0);

    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
